// File: rtl/conc_stim_pkg.sv
// Shared types for the concolic stimulus player.
// State encoding, playback mode codes and a saturating counter helper.
package conc_stim_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STEP_WAIT,
    DONE
  } state_t;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_LOOP    = 2'd1;
  localparam logic [1:0] MODE_STEP    = 2'd2;

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/conc_stim_mem.sv
// Vector store: sync write, async read, no reset.
// Out-of-range writes are dropped; out-of-range reads return zero.
module conc_stim_mem #(
  parameter int VEC_W = 3,
  parameter int DEPTH = 31,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [VEC_W-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [VEC_W-1:0] rd_data
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [VEC_W-1:0] mem [DEPTH];

  logic wr_ok;
  logic rd_ok;

  assign wr_ok = we && ({1'b0, wr_addr} < DEPTH_W);
  assign rd_ok = {1'b0, rd_addr} < DEPTH_W;

  always_ff @(posedge clock) begin
    if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = rd_ok ? mem[rd_addr] : '0;

endmodule

// File: rtl/conc_stim_player.sv
// Stimulus-vector player: replays stored vectors onto DUT inputs.
// Supports one-shot, loop and single-step playback with start/stop.
module conc_stim_player
  import conc_stim_pkg::*;
#(
  parameter int               VEC_W    = 3,
  parameter int               DEPTH    = 31,
  parameter int               AW       = $clog2(DEPTH),
  parameter logic [VEC_W-1:0] IDLE_VEC = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_we,
  input  logic [AW-1:0]    load_addr,
  input  logic [VEC_W-1:0] load_data,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic [1:0]       mode,
  input  logic [AW:0]      length,
  output logic [VEC_W-1:0] vec_out,
  output logic             vec_valid,
  output logic [AW-1:0]    vec_idx,
  output logic             busy,
  output logic             done,
  output logic [7:0]       wrap_count
);

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_MAX = AW'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [AW-1:0]    last_q, last_d;
  logic             loop_q, loop_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic [7:0]       wrap_q, wrap_d;

  logic [VEC_W-1:0] rd_data;
  logic [AW-1:0]    last_eff;
  logic             present;

  conc_stim_mem #(
    .VEC_W (VEC_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clock   (clock),
    .we      (load_we),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_addr (pc_q),
    .rd_data (rd_data)
  );

  // Zero or oversize length plays the whole store.
  always_comb begin
    if (length == '0 || length > DEPTH_W) begin
      last_eff = LAST_MAX;
    end else begin
      last_eff = AW'(length - 1'b1);
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    last_d  = last_q;
    loop_d  = loop_q;
    vec_d   = vec_q;
    idx_d   = idx_q;
    valid_d = 1'b0;
    done_d  = done_q;
    wrap_d  = wrap_q;
    present = 1'b0;

    if (stop) begin
      state_d = IDLE;
      vec_d   = IDLE_VEC;
      pc_d    = '0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (state_q == DONE) begin
            done_d = 1'b1;
          end
          if (start) begin
            loop_d  = (mode == MODE_LOOP);
            last_d  = last_eff;
            pc_d    = '0;
            wrap_d  = '0;
            done_d  = 1'b0;
            state_d = (mode == MODE_STEP) ? STEP_WAIT : RUN;
          end
        end
        RUN:       present = 1'b1;
        STEP_WAIT: present = step;
        default:   state_d = IDLE;
      endcase

      if (present) begin
        vec_d   = rd_data;
        idx_d   = pc_q;
        valid_d = 1'b1;
        if (pc_q == last_q) begin
          if (loop_q) begin
            pc_d   = '0;
            wrap_d = sat_inc8(wrap_q);
          end else begin
            state_d = DONE;
          end
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      last_q  <= LAST_MAX;
      loop_q  <= 1'b0;
      vec_q   <= IDLE_VEC;
      idx_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      last_q  <= last_d;
      loop_q  <= loop_d;
      vec_q   <= vec_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign vec_out    = vec_q;
  assign vec_valid  = valid_q;
  assign vec_idx    = idx_q;
  assign busy       = (state_q == RUN) || (state_q == STEP_WAIT);
  assign done       = done_q;
  assign wrap_count = wrap_q;

endmodule

// File: tb/tb_conc_stim_player.sv
// Bench for conc_stim_player: directed tables plus a random run
// scored against a counting model of the playback rules.
module tb_conc_stim_player;

  localparam int VEC_W = 3;
  localparam int DEPTH = 31;
  localparam int AW    = 5;

  logic             clock = 1'b0;
  logic             reset;
  logic             load_we;
  logic [AW-1:0]    load_addr;
  logic [VEC_W-1:0] load_data;
  logic             start;
  logic             stop;
  logic             step;
  logic [1:0]       mode;
  logic [AW:0]      length;
  logic [VEC_W-1:0] vec_out;
  logic             vec_valid;
  logic [AW-1:0]    vec_idx;
  logic             busy;
  logic             done;
  logic [7:0]       wrap_count;

  conc_stim_player #(
    .VEC_W    (VEC_W),
    .DEPTH    (DEPTH),
    .AW       (AW),
    .IDLE_VEC ('0)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .load_we    (load_we),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .start      (start),
    .stop       (stop),
    .step       (step),
    .mode       (mode),
    .length     (length),
    .vec_out    (vec_out),
    .vec_valid  (vec_valid),
    .vec_idx    (vec_idx),
    .busy       (busy),
    .done       (done),
    .wrap_count (wrap_count)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  logic [2:0] mref [32];

  typedef struct {
    logic       st;
    logic       sp;
    logic       stp;
    logic [1:0] md;
    logic [5:0] ln;
    logic [2:0] vec;
    logic       vld;
    logic [4:0] idx;
    logic       bsy;
    logic       dn;
    logic [7:0] wc;
  } row_t;

  row_t tbl[$];

  // reference model state
  int         m_phase;
  bit         m_loop;
  bit         m_step;
  int         m_len;
  int         m_n;
  logic [2:0] m_vec;
  logic [4:0] m_idx;
  logic       m_valid;
  logic       m_done;
  logic [7:0] m_wrap;

  function automatic logic [31:0] pk(
    input logic [2:0] v, input logic vl, input logic [4:0] ix,
    input logic b, input logic d, input logic [7:0] w
  );
    return {13'd0, w, d, b, ix, vl, v};
  endfunction

  function automatic logic [31:0] outs();
    return {13'd0, wrap_count, done, busy, vec_idx, vec_valid, vec_out};
  endfunction

  task automatic check(
    input string name, input logic [31:0] act, input logic [31:0] exp
  );
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void add(
    input logic st, input logic sp, input logic stp,
    input logic [1:0] md, input logic [5:0] ln,
    input logic [2:0] vec, input logic vld, input logic [4:0] idx,
    input logic bsy, input logic dn, input logic [7:0] wc
  );
    row_t r;
    r.st = st; r.sp = sp; r.stp = stp; r.md = md; r.ln = ln;
    r.vec = vec; r.vld = vld; r.idx = idx;
    r.bsy = bsy; r.dn = dn; r.wc = wc;
    tbl.push_back(r);
  endfunction

  task automatic run_table(input string tag);
    foreach (tbl[i]) begin
      start  = tbl[i].st;
      stop   = tbl[i].sp;
      step   = tbl[i].stp;
      mode   = tbl[i].md;
      length = tbl[i].ln;
      @(negedge clock);
      check($sformatf("%s[%0d]", tag, i), outs(),
            pk(tbl[i].vec, tbl[i].vld, tbl[i].idx,
               tbl[i].bsy, tbl[i].dn, tbl[i].wc));
    end
    start = 0; stop = 0; step = 0; mode = 0; length = 0;
    tbl.delete();
  endtask

  task automatic load(input logic [4:0] a, input logic [2:0] d);
    load_we = 1; load_addr = a; load_data = d;
    @(negedge clock);
    load_we = 0;
    if (a < 5'(DEPTH)) mref[a] = d;
  endtask

  // One clock edge of playback expressed as counts of vectors played.
  function automatic void model_edge(
    input logic st, input logic sp, input logic stp,
    input logic we, input logic [4:0] a, input logic [2:0] d,
    input logic [1:0] md, input logic [5:0] ln
  );
    bit was_fin = (m_phase == 2);
    int ix;
    int w;
    m_valid = 0;
    if (sp) begin
      m_phase = 0; m_vec = 0; m_done = 0; m_n = 0;
    end else if (m_phase == 1) begin
      if (!m_step || stp) begin
        ix = m_n % m_len;
        m_vec = mref[ix];
        m_idx = 5'(ix);
        m_valid = 1;
        m_n++;
        if (m_loop) begin
          w = m_n / m_len;
          m_wrap = (w > 255) ? 8'd255 : 8'(w);
        end else if (m_n == m_len) begin
          m_phase = 2;
        end
      end
    end else if (st) begin
      m_loop = (md == 2'd1);
      m_step = (md == 2'd2);
      m_len = (ln == 0 || ln > 6'(DEPTH)) ? DEPTH : int'(ln);
      m_n = 0; m_wrap = 0; m_phase = 1; m_done = 0;
    end else if (was_fin) begin
      m_done = 1;
    end
    if (we && a < 5'(DEPTH)) mref[a] = d;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int lens [4];
    int cnts [4];
    int cnt;
    reset = 1; load_we = 0; load_addr = 0; load_data = 0;
    start = 0; stop = 0; step = 0; mode = 0; length = 0;
    @(negedge clock);
    @(negedge clock);
    check("reset", outs(), pk(0, 0, 0, 0, 0, 0));
    reset = 0;
    @(negedge clock);

    for (int i = 0; i < 5; i++) load(5'(i), 3'(i + 1));

    add(1, 0, 0, 0, 5, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++)
      add(0, 0, 0, 0, 0, 3'(i + 1), 1, 5'(i), i < 4, 0, 0);
    add(0, 0, 0, 0, 0, 3'd5, 0, 5'd4, 0, 1, 0);
    add(0, 0, 0, 0, 0, 3'd5, 0, 5'd4, 0, 1, 0);
    run_table("oneshot");

    add(1, 0, 0, 1, 3, 3'd5, 0, 5'd4, 1, 0, 0);
    for (int k = 0; k < 10; k++)
      add(0, 0, 0, 0, 0, 3'(k % 3 + 1), 1, 5'(k % 3), 1, 0, 8'((k + 1) / 3));
    add(1, 1, 0, 0, 2, 3'd0, 0, 5'd0, 0, 0, 8'd3);
    add(1, 0, 0, 0, 2, 3'd0, 0, 5'd0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 3'd1, 1, 5'd0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 3'd2, 1, 5'd1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 3'd2, 0, 5'd1, 0, 1, 0);
    run_table("loop");

    add(1, 0, 0, 2, 2, 3'd2, 0, 5'd1, 1, 0, 0);
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 3; w++)
        add(0, 0, 0, 0, 0, (s == 0) ? 3'd2 : 3'd1, 0,
            (s == 0) ? 5'd1 : 5'd0, 1, 0, 0);
      add(0, 0, 1, 0, 0, 3'(s + 1), 1, 5'(s), s == 0, 0, 0);
    end
    add(0, 0, 1, 0, 0, 3'd2, 0, 5'd1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 3'd2, 0, 5'd1, 0, 1, 0);
    run_table("step");

    for (int i = 0; i < DEPTH; i++) load(5'(i), 3'(i * 3 + 1));
    lens = '{0, 40, 31, 30};
    cnts = '{31, 31, 31, 30};
    for (int t = 0; t < 4; t++) begin
      start = 1; mode = 0; length = 6'(lens[t]);
      @(negedge clock);
      start = 0;
      cnt = 0;
      for (int c = 0; c < 45 && !done; c++) begin
        @(negedge clock);
        if (vec_valid) begin
          check($sformatf("full%0d_v%0d", lens[t], cnt),
                {24'd0, vec_idx, vec_out}, {24'd0, 5'(cnt), mref[cnt]});
          cnt++;
        end
      end
      check($sformatf("full%0d_cnt", lens[t]), 32'(cnt), 32'(cnts[t]));
      check($sformatf("full%0d_done", lens[t]), {31'd0, done}, 32'd1);
    end

    start = 1; mode = 1; length = 1;
    @(negedge clock);
    start = 0;
    repeat (300) @(negedge clock);
    check("wrap_sat", outs(), pk(mref[0], 1, 0, 1, 0, 8'd255));
    stop = 1;
    @(negedge clock);
    stop = 0;
    check("stop_hold_wrap", outs(), pk(0, 0, 0, 0, 0, 8'd255));

    start = 1; mode = 1; length = 4;
    @(negedge clock);
    start = 0;
    repeat (5) @(negedge clock);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1;
    #1 check("async_rst", outs(), pk(0, 0, 0, 0, 0, 0));
    @(negedge clock);
    reset = 0;
    add(1, 0, 0, 0, 4, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++)
      add(0, 0, 0, 0, 0, mref[i], 1, 5'(i), i < 3, 0, 0);
    add(0, 0, 0, 0, 0, mref[3], 0, 5'd3, 0, 1, 0);
    run_table("after_rst");

    reset = 1;
    @(negedge clock);
    reset = 0;
    m_phase = 0; m_loop = 0; m_step = 0; m_len = DEPTH; m_n = 0;
    m_vec = 0; m_idx = 0; m_valid = 0; m_done = 0; m_wrap = 0;
    for (int t = 0; t < 60; t++) begin
      int ncyc = $urandom_range(5, 80);
      for (int c = 0; c < ncyc; c++) begin
        start     = (c == 0) || ($urandom_range(0, 29) == 0);
        stop      = (c > 0) && ($urandom_range(0, 39) == 0);
        step      = 1'($urandom_range(0, 1));
        mode      = 2'($urandom_range(0, 3));
        length    = 6'($urandom_range(0, 63));
        load_we   = ($urandom_range(0, 3) == 0);
        load_addr = 5'($urandom_range(0, 31));
        load_data = 3'($urandom_range(0, 7));
        model_edge(start, stop, step, load_we, load_addr, load_data,
                   mode, length);
        @(negedge clock);
        check($sformatf("rand_t%0d_c%0d", t, c), outs(),
              pk(m_vec, m_valid, m_idx, m_phase == 1, m_done, m_wrap));
      end
    end
    start = 0; stop = 0; step = 0; load_we = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
